// File: rtl/fifo_in_controller.sv
// Push/pop sequencing for the 8x32 FIFO register file: pointers, occupancy, flags and ack/err status.
// Optional build macro FIFO_IN_ERR_EN enables wr_err/rd_err reporting and a sticky err_seen port.
module fifo_in_controller #(
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wAddr,
    output logic [ADDR_W-1:0] rf_rAddr,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   data_count,
    output logic              wr_ack,
    output logic              rd_ack,
    output logic              wr_err,
    output logic              rd_err,
    output logic [2:0]        state_dbg
`ifdef FIFO_IN_ERR_EN
    ,
    output logic              err_seen
`endif
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        NO_OP  = 3'd1,
        WRITE  = 3'd2,
        READ   = 3'd3,
        WR_RD  = 3'd4,
        WR_ERR = 3'd5,
        RD_ERR = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, empty_q, af_q;
    logic              wr_ok, rd_ok, wr_rej, rd_rej;
    logic              wr_ack_q, rd_ack_q, wr_err_q, rd_err_q;

    // Flags are registered, so acceptance never depends on this cycle's count update.
    assign wr_ok  = wr_en & ~full_q;
    assign rd_ok  = rd_en & ~empty_q;
    assign wr_rej = wr_en & full_q;
    assign rd_rej = rd_en & empty_q;
    assign rf_we  = wr_ok & reset_n;

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            if (wr_ok) tail_q <= tail_q + ADDR_W'(1);
            if (rd_ok) head_q <= head_q + ADDR_W'(1);
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W'(DEPTH));
            empty_q  <= (count_d == '0);
            af_q     <= (count_d >= CNT_W'(AF_LEVEL));
            wr_ack_q <= wr_ok;
            rd_ack_q <= rd_ok;
            wr_err_q <= wr_rej;
            rd_err_q <= rd_rej;
        end
    end

    // State records the previous cycle's dominant operation; flags carry the full detail.
    always_comb begin
        state_d = NO_OP;
        if (state_q == INIT) begin
            state_d = NO_OP;
        end else if (wr_ok && rd_ok) begin
            state_d = WR_RD;
        end else if (wr_ok) begin
            state_d = WRITE;
        end else if (rd_ok) begin
            state_d = READ;
        end else if (wr_rej) begin
            state_d = WR_ERR;
        end else if (rd_rej) begin
            state_d = RD_ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= INIT;
        else          state_q <= state_d;
    end

    assign rf_wAddr    = tail_q;
    assign rf_rAddr    = head_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = af_q;
    assign data_count  = count_q;
    assign wr_ack      = wr_ack_q;
    assign rd_ack      = rd_ack_q;
    assign state_dbg   = state_q;

`ifdef FIFO_IN_ERR_EN
    logic err_seen_q;

    always_ff @(posedge clk) begin
        if (!reset_n) err_seen_q <= 1'b0;
        else          err_seen_q <= err_seen_q | wr_rej | rd_rej;
    end

    assign wr_err   = wr_err_q;
    assign rd_err   = rd_err_q;
    assign err_seen = err_seen_q;
`else
    // Rejected requests are dropped without any report in this build.
    logic unused_err;
    assign unused_err = wr_err_q ^ rd_err_q;
    assign wr_err     = 1'b0;
    assign rd_err     = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_in_controller.sv
// Bench for fifo_in_controller: register file model, queue-based reference and decoupled monitors.
// Build with FIFO_IN_ERR_EN defined to also check wr_err/rd_err/err_seen.
module tb_fifo_in_controller;

    localparam int SW     = 20;
    localparam int ST_INIT = 0, ST_NOP = 1, ST_WR = 2, ST_RD = 3, ST_WRRD = 4, ST_WERR = 5, ST_RERR = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] wdata = '0;
    logic        rf_we, full, empty, almost_full, wr_ack, rd_ack, wr_err, rd_err;
    logic [2:0]  rf_wAddr, rf_rAddr, state_dbg;
    logic [3:0]  data_count;
    logic [31:0] mem [8];
    logic [31:0] rdata;
`ifdef FIFO_IN_ERR_EN
    logic        err_seen;
`endif

    int checks = 0;
    int failures = 0;

    logic [SW-1:0] exp_q[$];
    logic [31:0]   exp_data_q[$];
    logic [31:0]   mdl_q[$];
    int            pushes = 0, pops = 0, mdl_st = ST_INIT;
    bit            mdl_err_seen = 0;

    fifo_in_controller dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en),
        .rf_we(rf_we), .rf_wAddr(rf_wAddr), .rf_rAddr(rf_rAddr),
        .full(full), .empty(empty), .almost_full(almost_full), .data_count(data_count),
        .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_err(wr_err), .rd_err(rd_err),
        .state_dbg(state_dbg)
`ifdef FIFO_IN_ERR_EN
        , .err_seen(err_seen)
`endif
    );

    // clock / register file
    always #5 clk = ~clk;

    always @(posedge clk) if (rf_we) mem[rf_wAddr] <= wdata;
    assign rdata = mem[rf_rAddr];

    function automatic logic [SW-1:0] pack(bit wa, bit ra, bit we, bit re, int cnt, int hd, int tl, int st);
        logic [3:0] c4 = 4'(cnt);
        logic [2:0] h3 = 3'(hd % 8);
        logic [2:0] t3 = 3'(tl % 8);
        logic [2:0] s3 = 3'(st);
        return {wa, ra, we, re, cnt == 8, cnt == 0, cnt >= 6, c4, h3, t3, s3};
    endfunction

    // drivers
    task automatic do_reset(input bit wr, input bit rd);
        @(negedge clk);
        reset_n = 1'b0; wr_en = wr; rd_en = rd; wdata = 32'hDEAD_BEEF;
        mdl_q.delete();
        pushes = 0; pops = 0; mdl_st = ST_INIT; mdl_err_seen = 0;
        exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, ST_INIT));
        #1;
        checks++;
        if (rf_we !== 1'b0) begin
            failures++;
            $display("FAIL rf_we_reset: got %b want 0", rf_we);
        end
    endtask

    task automatic cycle(input bit wr, input bit rd, input logic [31:0] d);
        bit w, r, we, re;
        int nst;
        @(negedge clk);
        reset_n = 1'b1; wr_en = wr; rd_en = rd; wdata = d;
        w = wr && (mdl_q.size() < 8);
        r = rd && (mdl_q.size() > 0);
        if (r) exp_data_q.push_back(mdl_q[0]);
        if (mdl_st == ST_INIT) nst = ST_NOP;
        else if (w && r)       nst = ST_WRRD;
        else if (w)            nst = ST_WR;
        else if (r)            nst = ST_RD;
        else if (wr)           nst = ST_WERR;
        else if (rd)           nst = ST_RERR;
        else                   nst = ST_NOP;
        mdl_st = nst;
`ifdef FIFO_IN_ERR_EN
        we = wr && !w; re = rd && !r;
`else
        we = 0; re = 0;
`endif
        if ((wr && !w) || (rd && !r)) mdl_err_seen = 1;
        if (r) begin void'(mdl_q.pop_front()); pops++; end
        if (w) begin mdl_q.push_back(d); pushes++; end
        exp_q.push_back(pack(w, r, we, re, mdl_q.size(), pops, pushes, nst));
        #1;
        checks++;
        if (rf_we !== w) begin
            failures++;
            $display("FAIL rf_we: got %b want %b (wr=%b rd=%b)", rf_we, w, wr, rd);
        end
    endtask

    // scoreboard monitors
    always begin
        @(posedge clk); #1;
        if (exp_q.size() > 0) begin
            logic [SW-1:0] e, a;
            e = exp_q.pop_front();
            a = {wr_ack, rd_ack, wr_err, rd_err, full, empty, almost_full, data_count,
                 rf_rAddr, rf_wAddr, state_dbg};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL status: got %h want %h (ack/err/full/empty/af/cnt/head/tail/state)", a, e);
            end
        end
    end

    always begin
        @(negedge clk); #1;
        if (reset_n && rd_en && !empty) begin
            checks++;
            if (exp_data_q.size() == 0) begin
                failures++;
                $display("FAIL rdata_unexpected_pop: got %h want none", rdata);
            end else begin
                logic [31:0] e;
                e = exp_data_q.pop_front();
                if (rdata !== e) begin
                    failures++;
                    $display("FAIL rdata: got %h want %h", rdata, e);
                end
            end
        end
    end

    // stimulus
    initial begin
        do_reset(1, 1);
        for (int i = 1; i <= 8; i++) cycle(1, 0, 32'(8'h11 * i));
        cycle(1, 0, 32'h99);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0);
        cycle(0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) cycle(1, 0, $urandom);
            for (int i = 0; i < 5; i++) cycle(0, 1, 0);
        end
        for (int i = 0; i < 3; i++) cycle(1, 0, $urandom);
        cycle(1, 1, 32'hA5A5_0003);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0);
        cycle(1, 1, 32'hA5A5_0000);
        for (int i = 0; i < 7; i++) cycle(1, 0, $urandom);
        cycle(1, 1, 32'hA5A5_0008);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0);
        do_reset(1, 0);
        cycle(0, 1, 0);
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        @(posedge clk); #2;
        checks++;
        if (exp_q.size() != 0 || exp_data_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d pending want 0/0", exp_q.size(), exp_data_q.size());
        end
`ifdef FIFO_IN_ERR_EN
        checks++;
        if (err_seen !== mdl_err_seen) begin
            failures++;
            $display("FAIL err_seen: got %b want %b", err_seen, mdl_err_seen);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
